// File: rtl/sw_pkg.sv
// Shared constants, state encodings and bias helpers for the Smith-Waterman
// processing element family.
package sw_pkg;

    // Nucleotide encoding used by the DNA configuration.
    localparam logic [1:0] NT_A = 2'd0;
    localparam logic [1:0] NT_G = 2'd1;
    localparam logic [1:0] NT_T = 2'd2;
    localparam logic [1:0] NT_C = 2'd3;

    typedef enum logic [0:0] {
        SC_IDLE = 1'b0,
        SC_CALC = 1'b1
    } score_state_e;

    typedef enum logic [0:0] {
        HI_IDLE = 1'b0,
        HI_CALC = 1'b1
    } high_state_e;

    // Biased representation: a score of zero is stored as 2^(width-1).
    function automatic int zero_of(input int score_width);
        return 1 << (score_width - 1);
    endfunction

    // Value fed in at the matrix edge: zero for local alignment, the most
    // negative representable score for global alignment.
    function automatic int boundary_of(input int score_width, input int local_mode);
        return (local_mode != 0) ? zero_of(score_width) : 0;
    endfunction

endpackage

// File: rtl/sw_sat_add.sv
// Biased unsigned score plus a signed delta, clamped to the representable
// range [0, 2^SCORE_WIDTH - 1]. Purely combinational.
module sw_sat_add #(
    parameter int SCORE_WIDTH = 12,
    parameter int DELTA_WIDTH = SCORE_WIDTH + 1
) (
    input  logic                          [SCORE_WIDTH-1:0] score,
    input  logic signed                   [DELTA_WIDTH-1:0] delta,
    output logic                          [SCORE_WIDTH-1:0] result
);

    localparam int EW = SCORE_WIDTH + 2;

    logic signed [EW-1:0] sum;

    // Two guard bits: the top one flags underflow, the next one overflow.
    always_comb begin
        sum = $signed({2'b00, score}) + EW'(delta);
        if (sum[EW-1]) begin
            result = '0;
        end else if (sum[EW-2]) begin
            result = '1;
        end else begin
            result = sum[SCORE_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sw_pe_gen.sv
// Systolic Smith-Waterman / Needleman-Wunsch cell: one query symbol, affine
// gaps, saturating biased scores and best-score/column tracking along the chain.
module sw_pe_gen
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH = 12,
    parameter int SYM_WIDTH   = 2,
    parameter int COL_WIDTH   = 16,
    parameter int LOCAL       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q_load,
    input  logic [SYM_WIDTH-1:0]   q_sym,
    input  logic                   en_in,
    input  logic [SYM_WIDTH-1:0]   data_in,
    input  logic [SCORE_WIDTH-1:0] M_in,
    input  logic [SCORE_WIDTH-1:0] I_in,
    input  logic [SCORE_WIDTH-1:0] High_in,
    input  logic [COL_WIDTH-1:0]   Col_in,
    input  logic [SCORE_WIDTH-1:0] match,
    input  logic [SCORE_WIDTH-1:0] mismatch,
    input  logic [SCORE_WIDTH-1:0] gap_open,
    input  logic [SCORE_WIDTH-1:0] gap_extend,
    output logic [SYM_WIDTH-1:0]   data_out,
    output logic [SCORE_WIDTH-1:0] M_out,
    output logic [SCORE_WIDTH-1:0] I_out,
    output logic [SCORE_WIDTH-1:0] High_out,
    output logic [COL_WIDTH-1:0]   Col_out,
    output logic                   en_out,
    output logic                   vld
);

    localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(zero_of(SCORE_WIDTH));
    localparam logic [SCORE_WIDTH-1:0] B    = SCORE_WIDTH'(boundary_of(SCORE_WIDTH, LOCAL));
    localparam int                     DW   = SCORE_WIDTH + 1;
    localparam int                     NSAT = 4;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    score_state_e             score_state_reg, score_state_next;
    high_state_e              high_state_reg,  high_state_next;
    logic [SYM_WIDTH-1:0]     query_reg,    query_next;
    logic [SYM_WIDTH-1:0]     data_out_reg, data_out_next;
    logic [SCORE_WIDTH-1:0]   m_out_reg,    m_out_next;
    logic [SCORE_WIDTH-1:0]   i_out_reg,    i_out_next;
    logic [SCORE_WIDTH-1:0]   m_diag_reg,   m_diag_next;
    logic [SCORE_WIDTH-1:0]   i_diag_reg,   i_diag_next;
    logic [SCORE_WIDTH-1:0]   high_reg,     high_next;
    logic [COL_WIDTH-1:0]     col_reg,      col_next;
    logic [COL_WIDTH-1:0]     col_cnt_reg,  col_cnt_next;
    logic                     en_out_reg;
    logic                     vld_reg,      vld_next;

    // ------------------------------------------------------------------
    // Score stage datapath
    // ------------------------------------------------------------------
    logic                     first;
    logic [SCORE_WIDTH-1:0]   m_diag_eff, i_diag_eff, m_up, i_up;
    logic [SCORE_WIDTH-1:0]   diag_best, i_ext_base;
    logic signed [DW-1:0]     s_delta, open_delta, ext_delta;
    logic [SCORE_WIDTH-1:0]   sat_in    [NSAT];
    logic signed [DW-1:0]     sat_delta [NSAT];
    logic [SCORE_WIDTH-1:0]   sat_out   [NSAT];
    logic [SCORE_WIDTH-1:0]   m_new, i_open, i_new;

    always_comb begin
        // The first symbol of a stream sees the matrix edge, not stale state.
        first      = (score_state_reg == SC_IDLE) && en_in;
        m_diag_eff = first ? B : m_diag_reg;
        i_diag_eff = first ? B : i_diag_reg;
        m_up       = first ? B : m_out_reg;
        i_up       = first ? B : i_out_reg;

        diag_best  = (m_diag_eff > i_diag_eff) ? m_diag_eff : i_diag_eff;
        i_ext_base = (I_in > i_up) ? I_in : i_up;

        s_delta    = (data_in == query_reg) ? DW'($signed(match)) : DW'($signed(mismatch));
        open_delta = DW'($signed(gap_open)) + DW'($signed(gap_extend));
        ext_delta  = DW'($signed(gap_extend));

        // Saturation is monotone, so max-after-sat equals sat-after-max and
        // the gap-open candidates can be saturated separately.
        sat_in[0]    = diag_best;
        sat_delta[0] = s_delta;
        sat_in[1]    = M_in;
        sat_delta[1] = open_delta;
        sat_in[2]    = m_up;
        sat_delta[2] = open_delta;
        sat_in[3]    = i_ext_base;
        sat_delta[3] = ext_delta;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSAT; gi++) begin : g_sat
            sw_sat_add #(
                .SCORE_WIDTH (SCORE_WIDTH),
                .DELTA_WIDTH (DW)
            ) u_sat (
                .score  (sat_in[gi]),
                .delta  (sat_delta[gi]),
                .result (sat_out[gi])
            );
        end
    endgenerate

    always_comb begin
        m_new = sat_out[0];
        if ((LOCAL != 0) && (m_new < ZERO)) begin
            m_new = ZERO;
        end
        i_open = (sat_out[1] > sat_out[2]) ? sat_out[1] : sat_out[2];
        i_new  = (i_open > sat_out[3]) ? i_open : sat_out[3];
    end

    // ------------------------------------------------------------------
    // Score stage next-state
    // ------------------------------------------------------------------
    always_comb begin
        score_state_next = score_state_reg;
        query_next       = query_reg;
        data_out_next    = data_out_reg;
        m_out_next       = m_out_reg;
        i_out_next       = i_out_reg;
        m_diag_next      = m_diag_reg;
        i_diag_next      = i_diag_reg;
        col_cnt_next     = col_cnt_reg;

        case (score_state_reg)
            SC_IDLE: if (en_in)  score_state_next = SC_CALC;
            SC_CALC: if (!en_in) score_state_next = SC_IDLE;
            default:             score_state_next = SC_IDLE;
        endcase

        if (en_in) begin
            m_out_next    = m_new;
            i_out_next    = i_new;
            m_diag_next   = M_in;
            i_diag_next   = I_in;
            data_out_next = data_in;
            col_cnt_next  = first ? '0 : col_cnt_reg + COL_WIDTH'(1);
        end else if (score_state_reg == SC_IDLE) begin
            m_out_next  = B;
            i_out_next  = B;
            m_diag_next = B;
            i_diag_next = B;
        end

        // The query is frozen while a stream is in flight.
        if (q_load && (score_state_reg == SC_IDLE)) begin
            query_next = q_sym;
        end
    end

    // ------------------------------------------------------------------
    // High stage: aligned with en_out, consumes this cell's registered scores
    // ------------------------------------------------------------------
    logic [SCORE_WIDTH-1:0] own;
    logic [SCORE_WIDTH-1:0] inc_high;
    logic [COL_WIDTH-1:0]   inc_col;

    always_comb begin
        high_state_next = high_state_reg;
        high_next       = high_reg;
        col_next        = col_reg;

        own = (m_out_reg > i_out_reg) ? m_out_reg : i_out_reg;

        // Ties between neighbour and incumbent go to the neighbour's earlier column.
        if ((high_state_reg == HI_IDLE) || (High_in >= high_reg)) begin
            inc_high = High_in;
            inc_col  = Col_in;
        end else begin
            inc_high = high_reg;
            inc_col  = col_reg;
        end

        if (en_out_reg) begin
            if (own > inc_high) begin
                high_next = own;
                col_next  = col_cnt_reg;
            end else begin
                high_next = inc_high;
                col_next  = inc_col;
            end
        end

        case (high_state_reg)
            HI_IDLE: if (en_out_reg)  high_state_next = HI_CALC;
            HI_CALC: if (!en_out_reg) high_state_next = HI_IDLE;
            default:                  high_state_next = HI_IDLE;
        endcase

        // en_out is about to fall: the high score settles on this edge.
        vld_next = en_out_reg && !en_in;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            score_state_reg <= SC_IDLE;
            high_state_reg  <= HI_IDLE;
            query_reg       <= '0;
            data_out_reg    <= '0;
            m_out_reg       <= ZERO;
            i_out_reg       <= ZERO;
            m_diag_reg      <= ZERO;
            i_diag_reg      <= ZERO;
            high_reg        <= ZERO;
            col_reg         <= '0;
            col_cnt_reg     <= '0;
            en_out_reg      <= 1'b0;
            vld_reg         <= 1'b0;
        end else begin
            score_state_reg <= score_state_next;
            high_state_reg  <= high_state_next;
            query_reg       <= query_next;
            data_out_reg    <= data_out_next;
            m_out_reg       <= m_out_next;
            i_out_reg       <= i_out_next;
            m_diag_reg      <= m_diag_next;
            i_diag_reg      <= i_diag_next;
            high_reg        <= high_next;
            col_reg         <= col_next;
            col_cnt_reg     <= col_cnt_next;
            en_out_reg      <= en_in;
            vld_reg         <= vld_next;
        end
    end

    assign data_out = data_out_reg;
    assign M_out    = m_out_reg;
    assign I_out    = i_out_reg;
    assign High_out = high_reg;
    assign Col_out  = col_reg;
    assign en_out   = en_out_reg;
    assign vld      = vld_reg;

endmodule

// File: tb/tb_sw_pe_gen.sv
// Scoreboard bench for sw_pe_gen: a local-mode and a global-mode cell driven
// with directed streams whose scores were worked out by hand.
module tb_sw_pe_gen;
    import sw_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_load;
    logic [1:0]  q_sym, data_in;
    logic        en_l, en_g;
    logic [11:0] m_in_l, i_in_l, high_in_l, m_in_g, i_in_g, high_in_g;
    logic [15:0] col_in_l, col_in_g;
    logic [11:0] match, mismatch, gap_open, gap_extend;

    logic [1:0]  l_data_out, g_data_out;
    logic [11:0] l_m_out, l_i_out, l_high, g_m_out, g_i_out, g_high;
    logic [15:0] l_col, g_col;
    logic        l_en_out, l_vld, g_en_out, g_vld;

    always #5 clk = ~clk;

    sw_pe_gen #(.SCORE_WIDTH(12), .SYM_WIDTH(2), .COL_WIDTH(16), .LOCAL(1)) u_dut_l (
        .clk(clk), .rst(rst), .q_load(q_load), .q_sym(q_sym),
        .en_in(en_l), .data_in(data_in), .M_in(m_in_l), .I_in(i_in_l),
        .High_in(high_in_l), .Col_in(col_in_l),
        .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
        .data_out(l_data_out), .M_out(l_m_out), .I_out(l_i_out),
        .High_out(l_high), .Col_out(l_col), .en_out(l_en_out), .vld(l_vld)
    );

    sw_pe_gen #(.SCORE_WIDTH(12), .SYM_WIDTH(2), .COL_WIDTH(16), .LOCAL(0)) u_dut_g (
        .clk(clk), .rst(rst), .q_load(q_load), .q_sym(q_sym),
        .en_in(en_g), .data_in(data_in), .M_in(m_in_g), .I_in(i_in_g),
        .High_in(high_in_g), .Col_in(col_in_g),
        .match(match), .mismatch(mismatch), .gap_open(gap_open), .gap_extend(gap_extend),
        .data_out(g_data_out), .M_out(g_m_out), .I_out(g_i_out),
        .High_out(g_high), .Col_out(g_col), .en_out(g_en_out), .vld(g_vld)
    );

    typedef struct {
        logic [11:0] m;
        logic [11:0] i;
        logic [1:0]  d;
        int          cyc;
    } sc_t;

    typedef struct {
        logic [11:0] h;
        logic [15:0] c;
        int          cyc;
    } hi_t;

    sc_t sq_l[$], sq_g[$];
    hi_t hq_l[$], hq_g[$];

    int n_chk    = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: output present with no expected entry queued", name);
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic send(input bit g, input logic [1:0] sym, input logic [11:0] em, input logic [11:0] ei);
        sc_t s;
        data_in = sym;
        if (g) en_g = 1'b1;
        else   en_l = 1'b1;
        tick();
        s.m = em; s.i = ei; s.d = sym; s.cyc = edge_cnt;
        if (g) sq_g.push_back(s);
        else   sq_l.push_back(s);
        $display("sent %s sym=%0d expect M=%0d I=%0d at edge %0d", g ? "glob" : "local", sym, em, ei, edge_cnt);
    endtask

    task automatic end_stream(input bit g, input logic [11:0] eh, input logic [15:0] ec);
        hi_t h;
        en_l = 1'b0;
        en_g = 1'b0;
        tick();
        h.h = eh; h.c = ec; h.cyc = edge_cnt;
        if (g) hq_g.push_back(h);
        else   hq_l.push_back(h);
        $display("end  %s stream expect High=%0d Col=%0d at edge %0d", g ? "glob" : "local", eh, ec, edge_cnt);
    endtask

    // Monitors: pop and compare whenever a cell presents scores or a vld pulse.
    always @(negedge clk) begin
        sc_t s;
        hi_t h;
        if (l_en_out) begin
            if (sq_l.size() == 0) unexp("l_en_out");
            else begin
                s = sq_l.pop_front();
                chk("l_m_out", l_m_out, s.m);
                chk("l_i_out", l_i_out, s.i);
                chk("l_data_out", l_data_out, s.d);
                chk("l_out_edge", edge_cnt, s.cyc);
            end
        end
        if (l_vld) begin
            if (hq_l.size() == 0) unexp("l_vld");
            else begin
                h = hq_l.pop_front();
                chk("l_high_out", l_high, h.h);
                chk("l_col_out", l_col, h.c);
                chk("l_vld_edge", edge_cnt, h.cyc);
            end
        end
    end

    always @(negedge clk) begin
        sc_t s;
        hi_t h;
        if (g_en_out) begin
            if (sq_g.size() == 0) unexp("g_en_out");
            else begin
                s = sq_g.pop_front();
                chk("g_m_out", g_m_out, s.m);
                chk("g_i_out", g_i_out, s.i);
                chk("g_data_out", g_data_out, s.d);
                chk("g_out_edge", edge_cnt, s.cyc);
            end
        end
        if (g_vld) begin
            if (hq_g.size() == 0) unexp("g_vld");
            else begin
                h = hq_g.pop_front();
                chk("g_high_out", g_high, h.h);
                chk("g_col_out", g_col, h.c);
                chk("g_vld_edge", edge_cnt, h.cyc);
            end
        end
    end

    task automatic chk_local_reset(input string tag);
        chk({tag, "_data_out"}, l_data_out, 0);
        chk({tag, "_m_out"}, l_m_out, 2048);
        chk({tag, "_i_out"}, l_i_out, 2048);
        chk({tag, "_high_out"}, l_high, 2048);
        chk({tag, "_col_out"}, l_col, 0);
        chk({tag, "_en_out"}, l_en_out, 0);
        chk({tag, "_vld"}, l_vld, 0);
    endtask

    initial begin
        rst = 1'b0; q_load = 1'b0; q_sym = NT_A; data_in = NT_A;
        en_l = 1'b0; en_g = 1'b0;
        m_in_l = 12'd2048; i_in_l = 12'd2048; high_in_l = 12'd2048; col_in_l = 16'd0;
        m_in_g = 12'd0;    i_in_g = 12'd0;    high_in_g = 12'd0;    col_in_g = 16'd0;
        match = 12'd2; mismatch = 12'hFFF; gap_open = 12'hFFE; gap_extend = 12'hFFF;

        repeat (3) tick();
        chk_local_reset("rst");
        chk("rst_g_m_out", g_m_out, 2048);
        chk("rst_g_high_out", g_high, 2048);
        rst = 1'b1;
        tick();

        // Load C and score a single matching C.
        q_load = 1'b1; q_sym = NT_C; tick(); q_load = 1'b0;
        send(0, NT_C, 12'd2050, 12'd2047);
        end_stream(0, 12'd2050, 16'd0);
        tick();

        // Load A; stream A,C,A.
        q_load = 1'b1; q_sym = NT_A; tick(); q_load = 1'b0;
        send(0, NT_A, 12'd2050, 12'd2047);
        send(0, NT_C, 12'd2048, 12'd2047);
        send(0, NT_A, 12'd2050, 12'd2047);
        end_stream(0, 12'd2050, 16'd0);
        tick();

        // Local floor; own never beats High_in, so Col_in carries through.
        col_in_l = 16'd5;
        send(0, NT_C, 12'd2048, 12'd2047);
        send(0, NT_C, 12'd2048, 12'd2047);
        end_stream(0, 12'd2048, 16'd5);
        tick();
        col_in_l = 16'd0;

        // Global alignment saturates low from boundary 0.
        send(1, NT_C, 12'd0, 12'd0);
        send(1, NT_C, 12'd0, 12'd0);
        end_stream(1, 12'd0, 16'd0);
        tick();

        // Upper saturation: M_diag 4095 + 2047 clamps to 4095.
        match = 12'd2047;
        m_in_l = 12'd4095;
        send(0, NT_C, 12'd2048, 12'd4092);
        m_in_l = 12'd2048;
        send(0, NT_A, 12'd4095, 12'd4091);
        end_stream(0, 12'd4095, 16'd1);
        tick();
        match = 12'd2;

        // q_load mid-stream must be ignored: third A still matches.
        send(0, NT_A, 12'd2050, 12'd2047);
        q_load = 1'b1; q_sym = NT_C;
        send(0, NT_C, 12'd2048, 12'd2047);
        q_load = 1'b0;
        send(0, NT_A, 12'd2050, 12'd2047);
        end_stream(0, 12'd2050, 16'd0);
        tick();

        // Back-to-back streams with a one-cycle gap.
        send(0, NT_A, 12'd2050, 12'd2047);
        send(0, NT_A, 12'd2050, 12'd2047);
        send(0, NT_C, 12'd2048, 12'd2047);
        send(0, NT_G, 12'd2048, 12'd2047);
        end_stream(0, 12'd2050, 16'd0);
        send(0, NT_C, 12'd2048, 12'd2047);
        send(0, NT_A, 12'd2050, 12'd2047);
        send(0, NT_A, 12'd2050, 12'd2047);
        send(0, NT_T, 12'd2048, 12'd2047);
        end_stream(0, 12'd2050, 16'd1);
        tick();

        // Reset mid-stream: no vld, everything back to reset values.
        send(0, NT_A, 12'd2050, 12'd2047);
        send(0, NT_C, 12'd2048, 12'd2047);
        rst = 1'b0; data_in = NT_A; en_l = 1'b1;
        repeat (3) tick();
        chk_local_reset("midrst");
        rst = 1'b1; en_l = 1'b0;
        repeat (2) tick();
        chk("post_rst_high_out", l_high, 2048);
        chk("post_rst_vld", l_vld, 0);
        send(0, NT_A, 12'd2050, 12'd2047);
        end_stream(0, 12'd2050, 16'd0);

        repeat (4) tick();
        chk("l_out_pending", sq_l.size(), 0);
        chk("l_vld_pending", hq_l.size(), 0);
        chk("g_out_pending", sq_g.size(), 0);
        chk("g_vld_pending", hq_g.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
